// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
// Default sizes describe the 32 x 32-bit core configuration.
package rf_pkg;

   localparam int DW_DEF   = 32;
   localparam int NREG_DEF = 32;
   localparam int AW_DEF   = $clog2(NREG_DEF);

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 31;

   typedef logic [AW_DEF-1:0] reg_addr_t;
   typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reservations set, writebacks clear, set wins on a tie.
// Busy outputs are bypassed so a same-cycle writeback unblocks decode immediately.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREG     = NREG_DEF,
   parameter  int LINK_IDX = NREG - 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          link_en,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   input  logic [AW-1:0] ra1_addr,
   input  logic [AW-1:0] ra2_addr,
   output logic          busy1,
   output logic          busy2,
   output logic [AW:0]   busy_cnt
);

   localparam logic [AW-1:0] LINK_A = AW'(LINK_IDX);
   localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     cnt_q, cnt_d;

   // NOTE: combinational blocks use blocking '=' with a default first, so later lines override earlier ones and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (wr_en)   busy_d[wr_addr] = 1'b0;
      if (link_en) busy_d[LINK_A]  = 1'b0;
      // The set comes last: a fresh reservation outranks a same-cycle writeback.
      if (rsv_en && rsv_addr != ZERO_A) busy_d[rsv_addr] = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_d = cnt_d + (AW+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      busy1 = (ra1_addr != ZERO_A) && busy_q[ra1_addr] &&
              !((wr_en && wr_addr == ra1_addr) || (link_en && ra1_addr == LINK_A));
      busy2 = (ra2_addr != ZERO_A) && busy_q[ra2_addr] &&
              !((wr_en && wr_addr == ra2_addr) || (link_en && ra2_addr == LINK_A));
   end

   assign busy_cnt = cnt_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Two-read / write+link register file with write-through bypass and busy scoreboard.
// Define RF_TRACE_EN to print every committed write and a register dump after each edge.
module rf_multiport_sb
   import rf_pkg::*;
#(
   parameter  int DW       = DW_DEF,
   parameter  int NREG     = NREG_DEF,
   parameter  int LINK_IDX = NREG - 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra1_addr,
   output logic [DW-1:0] rd1_data,
   input  logic [AW-1:0] ra2_addr,
   output logic [DW-1:0] rd2_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          link_en,
   input  logic [DW-1:0] link_data,
   output logic [DW-1:0] ra_data,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   output logic          busy1,
   output logic          busy2,
   output logic [AW:0]   busy_cnt
);

   localparam logic [AW-1:0] LINK_A = AW'(LINK_IDX);
   localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

   logic [DW-1:0] regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset as flops because software relies on all GPRs reading 0 after reset; it cannot map to RAM.
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (wr_en && wr_addr != ZERO_A) regs_q[wr_addr] <= wr_data;
         // Issued after the general write so the link port wins a collision.
         if (link_en) regs_q[LINK_A] <= link_data;
      end
   end

   function automatic logic [DW-1:0] read_mux(
      input logic [AW-1:0] addr,
      input logic [DW-1:0] stored,
      input logic          lk_en,
      input logic [DW-1:0] lk_data,
      input logic          w_en,
      input logic [AW-1:0] w_addr,
      input logic [DW-1:0] w_data
   );
      if (addr == ZERO_A)                 return '0;
      else if (lk_en && addr == LINK_A)   return lk_data;
      else if (w_en && addr == w_addr)    return w_data;
      else                                return stored;
   endfunction

   always_comb begin
      rd1_data = read_mux(ra1_addr, regs_q[ra1_addr], link_en, link_data, wr_en, wr_addr, wr_data);
      rd2_data = read_mux(ra2_addr, regs_q[ra2_addr], link_en, link_data, wr_en, wr_addr, wr_data);
      ra_data  = read_mux(LINK_A, regs_q[LINK_A], link_en, link_data, wr_en, wr_addr, wr_data);
   end

   rf_scoreboard #(
      .NREG     (NREG),
      .LINK_IDX (LINK_IDX)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .link_en  (link_en),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ra1_addr (ra1_addr),
      .ra2_addr (ra2_addr),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy_cnt (busy_cnt)
   );

`ifdef RF_TRACE_EN
   logic          tr_wr_q, tr_lk_q;
   logic [AW-1:0] tr_wa_q;
   logic [DW-1:0] tr_wd_q, tr_ld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tr_wr_q <= 1'b0;
         tr_lk_q <= 1'b0;
         tr_wa_q <= '0;
         tr_wd_q <= '0;
         tr_ld_q <= '0;
      end else begin
         tr_wr_q <= wr_en && wr_addr != ZERO_A && !(link_en && wr_addr == LINK_A);
         tr_lk_q <= link_en;
         tr_wa_q <= wr_addr;
         tr_wd_q <= wr_data;
         tr_ld_q <= link_data;
      end
   end

   // Printed half a cycle later so the dump shows the state the edge produced.
   always @(negedge clk) begin
      if (rst_n && (tr_wr_q || tr_lk_q)) begin
         if (tr_wr_q) $display("rf write R[%02d]=%8X", tr_wa_q, tr_wd_q);
         if (tr_lk_q) $display("rf link  R[%02d]=%8X", LINK_IDX, tr_ld_q);
         for (int b = 0; b < NREG; b += 8) begin
            $display("R[%02d-%02d]=%8X, %8X, %8X, %8X, %8X, %8X, %8X, %8X", b, b + 7,
                     regs_q[b], regs_q[b+1], regs_q[b+2], regs_q[b+3],
                     regs_q[b+4], regs_q[b+5], regs_q[b+6], regs_q[b+7]);
         end
      end
   end
`else
   // Default build carries no trace logic.
`endif

endmodule
